riscv_test_monitor: RTL and testbench

Synthesizable test-completion monitor between the minisoc core and the riscv-tests bench. It snoops the core's register-file write port, shadows the test-number register (x3) and the two signature registers (x28, x29), and resolves each run to PASS, FAIL or TIMEOUT. It also keeps cycle and retired-instruction counts. The bench and FPGA status LEDs read its outputs directly, so nothing needs to peek into the register file hierarchy.

---
 rtl/riscv_test_monitor.sv | 106 ++++++++++
 tb/tb_riscv_test_monitor.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_test_monitor.sv
// Test-completion monitor: snoops register-file writes, shadows x3/x28/x29 and
// resolves the run to PASS, FAIL or TIMEOUT while counting cycles and retirements.
module riscv_test_monitor #(
  parameter int unsigned TIMEOUT_CYCLES = 4000,
  parameter logic [4:0]  TESTNUM_REG    = 5'd3,
  parameter logic [4:0]  SIG1_REG       = 5'd28,
  parameter logic [4:0]  SIG2_REG       = 5'd29
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rf_wen,
  input  logic [4:0]  rf_waddr,
  input  logic [31:0] rf_wdata,
  input  logic        retire,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [31:0] test_num,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  localparam logic [31:0] LP_LAST_CYCLE = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] LP_SAT        = 32'hFFFF_FFFF;

  state_t      r_state;
  state_t      w_state_nx;
  logic [31:0] r_sh3;
  logic [31:0] r_sh28;
  logic [31:0] r_sh29;
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instret_cnt;

  logic        w_wr;
  logic        w_wr3;
  logic        w_wr28;
  logic        w_wr29;
  logic [31:0] w_nx28;
  logic [31:0] w_nx29;
  logic        w_pass_cond;
  logic        w_fail_cond;

  // x0 is hardwired to zero in the core, so writes to it never reach a shadow.
  assign w_wr   = rf_wen && (rf_waddr != 5'd0);
  assign w_wr3  = w_wr && (rf_waddr == TESTNUM_REG);
  assign w_wr28 = w_wr && (rf_waddr == SIG1_REG);
  assign w_wr29 = w_wr && (rf_waddr == SIG2_REG);

  assign w_nx28      = w_wr28 ? rf_wdata : r_sh28;
  assign w_nx29      = w_wr29 ? rf_wdata : r_sh29;
  assign w_pass_cond = (w_nx28 == 32'd1) && (w_nx29 == 32'd1);
  assign w_fail_cond = (w_nx28 == 32'd1) && (w_nx29 == 32'd2);

  always_comb begin
    w_state_nx = r_state;
    if (r_state == ST_RUN) begin
      if (w_pass_cond)                        w_state_nx = ST_PASS;
      else if (w_fail_cond)                   w_state_nx = ST_FAIL;
      else if (r_cycle_cnt == LP_LAST_CYCLE)  w_state_nx = ST_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // The cycle counter stops on the resolving edge so it reports the last RUN cycle index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh3         <= '0;
      r_sh28        <= '0;
      r_sh29        <= '0;
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      if (w_wr3)  r_sh3  <= rf_wdata;
      if (w_wr28) r_sh28 <= rf_wdata;
      if (w_wr29) r_sh29 <= rf_wdata;
      if ((w_state_nx == ST_RUN) && (r_cycle_cnt != LP_SAT))
        r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (retire && (r_instret_cnt != LP_SAT))
        r_instret_cnt <= r_instret_cnt + 32'd1;
    end
  end

  assign pass        = (r_state == ST_PASS);
  assign fail        = (r_state == ST_FAIL);
  assign timeout     = (r_state == ST_TIMEOUT);
  assign done        = pass | fail | timeout;
  assign test_num    = r_sh3;
  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Bench for riscv_test_monitor: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a register-array reference model.
module tb_riscv_test_monitor;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rf_wen = 1'b0;
  logic [4:0]  rf_waddr = '0;
  logic [31:0] rf_wdata = '0;
  logic        retire = 1'b0;
  logic        done, pass, fail, timeout;
  logic [31:0] test_num, cycle_cnt, instret_cnt;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  riscv_test_monitor #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .retire(retire), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .test_num(test_num), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: an architectural register array plus a run outcome.
  localparam int M_RUN = 0, M_PASS = 1, M_FAIL = 2, M_TO = 3;
  int          m_outcome = M_RUN;
  logic [31:0] m_regs [32];
  logic [31:0] m_cycles = '0;
  logic [31:0] m_instret = '0;

  initial foreach (m_regs[i]) m_regs[i] = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_outcome = M_RUN;
      foreach (m_regs[i]) m_regs[i] = '0;
      m_cycles  = '0;
      m_instret = '0;
    end else if (m_outcome == M_RUN) begin
      if (rf_wen && rf_waddr != 5'd0) m_regs[rf_waddr] = rf_wdata;
      if (retire && m_instret != 32'hFFFF_FFFF) m_instret = m_instret + 1;
      if (m_regs[28] == 1 && m_regs[29] == 1)      m_outcome = M_PASS;
      else if (m_regs[28] == 1 && m_regs[29] == 2) m_outcome = M_FAIL;
      else if (m_cycles == TO - 1)                 m_outcome = M_TO;
      else if (m_cycles != 32'hFFFF_FFFF)          m_cycles = m_cycles + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_pass",    {31'd0, pass},    {31'd0, m_outcome == M_PASS});
      chk("m_fail",    {31'd0, fail},    {31'd0, m_outcome == M_FAIL});
      chk("m_timeout", {31'd0, timeout}, {31'd0, m_outcome == M_TO});
      chk("m_done",    {31'd0, done},    {31'd0, m_outcome != M_RUN});
      chk("m_test_num", test_num,    m_regs[3]);
      chk("m_cycle",    cycle_cnt,   m_cycles);
      chk("m_instret",  instret_cnt, m_instret);
    end
  end

  // Present inputs for one clock edge, then return 1 time unit after that edge.
  task automatic step(input logic w, input logic [4:0] a, input logic [31:0] d,
                      input logic r = 1'b0, input logic rs = 1'b0);
    rf_wen = w; rf_waddr = a; rf_wdata = d; retire = r; rst = rs;
    @(posedge clk);
    #1;
    rf_wen = 1'b0; rf_waddr = '0; rf_wdata = '0; retire = 1'b0; rst = 1'b0;
  endtask

  task automatic do_reset();
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    cmp_en = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_test_num", test_num, 32'd0);
    chk("rst_cycle", cycle_cnt, 32'd0);

    // Pass
    step(1'b1, 5'd3, 32'd5);
    step(1'b1, 5'd28, 32'd1);
    chk("pass_pending", {31'd0, done}, 32'd0);
    step(1'b1, 5'd29, 32'd1);
    chk("pass_pass", {31'd0, pass}, 32'd1);
    chk("pass_done", {31'd0, done}, 32'd1);
    chk("pass_tn", test_num, 32'd5);
    chk("pass_others", {30'd0, fail, timeout}, 32'd0);

    // Fail, then a late x29=1 must not flip it
    do_reset();
    step(1'b1, 5'd3, 32'd7);
    step(1'b1, 5'd29, 32'd2);
    step(1'b1, 5'd28, 32'd1);
    chk("fail_fail", {31'd0, fail}, 32'd1);
    chk("fail_tn", test_num, 32'd7);
    step(1'b1, 5'd29, 32'd1);
    chk("fail_sticky", {30'd0, fail, pass}, 32'd2);

    // Timeout with 3 retirements
    do_reset();
    for (int i = 0; i < int'(TO); i++)
      step(1'b0, 5'd0, 32'd0, (i == 2 || i == 5 || i == 8));
    chk("to_timeout", {31'd0, timeout}, 32'd1);
    chk("to_cycle", cycle_cnt, 32'd15);
    chk("to_instret", instret_cnt, 32'd3);
    for (int i = 0; i < 5; i++) step(1'b1, 5'd28, 32'd1, 1'b1);
    chk("to_frozen_cycle", cycle_cnt, 32'd15);
    chk("to_frozen_instret", instret_cnt, 32'd3);

    // Tie: signature completes on the timeout cycle
    do_reset();
    step(1'b1, 5'd28, 32'd1);
    idle(int'(TO) - 2);
    chk("tie_cycle_before", cycle_cnt, 32'd15);
    step(1'b1, 5'd29, 32'd1);
    chk("tie_pass", {30'd0, pass, timeout}, 32'd2);

    // Filtering
    do_reset();
    step(1'b1, 5'd0, 32'd1);
    step(1'b1, 5'd28, 32'd1);
    step(1'b1, 5'd29, 32'd3);
    step(1'b1, 5'd30, 32'd1);
    chk("filt_run", {31'd0, done}, 32'd0);
    step(1'b1, 5'd29, 32'd1);
    chk("filt_pass", {31'd0, pass}, 32'd1);

    // Reset mid-run with a simultaneous write that must be dropped
    step(1'b1, 5'd28, 32'd1, 1'b0, 1'b1);
    chk("mrst_done", {31'd0, done}, 32'd0);
    chk("mrst_cycle", cycle_cnt, 32'd0);
    step(1'b1, 5'd29, 32'd1);
    chk("mrst_no_pass", {31'd0, pass}, 32'd0);

    // Cancel: x28 rewritten to 0 before x29 lands
    do_reset();
    step(1'b1, 5'd28, 32'd1);
    step(1'b1, 5'd28, 32'd0);
    step(1'b1, 5'd29, 32'd1);
    chk("cancel_run", {31'd0, done}, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [4:0]  a;
      logic [31:0] d;
      int unsigned sel;
      sel = $urandom_range(0, 5);
      case (sel)
        0: a = 5'd0;
        1: a = 5'd3;
        2, 3: a = 5'd28 + 5'($urandom_range(0, 1));
        4: a = 5'd30;
        default: a = 5'($urandom);
      endcase
      sel = $urandom_range(0, 4);
      d = (sel == 4) ? $urandom : 32'(sel);
      step(1'($urandom), a, d, 1'($urandom), ($urandom_range(0, 24) == 0));
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
